// File: rtl/bmp_pixel_streamer.sv
// BMP pixel-data streamer: packs BGR bytes into 24-bit pixels, strips row padding
// and tracks x/y coordinates, sync flags and a completed-frame counter.
module bmp_pixel_streamer #(
   parameter int unsigned PIXEL_SIZE = 24,
   parameter int unsigned WORD_SIZE  = 8,
   parameter int unsigned COORD_W    = 32,
   parameter int unsigned DIM_W      = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  en_i,
   input  logic [DIM_W-1:0]      img_width_i,
   input  logic [DIM_W-1:0]      img_height_i,
   input  logic [WORD_SIZE-1:0]  byte_in_i,
   input  logic                  byte_valid_i,
   output logic                  byte_ready_o,
   output logic [PIXEL_SIZE-1:0] pixel_o,
   output logic                  pixel_valid_o,
   output logic [COORD_W-1:0]    x_o,
   output logic [COORD_W-1:0]    y_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic [COORD_W-1:0]    frame_o,
   output logic                  cfg_err_o
);

   typedef enum logic [1:0] {StB0, StB1, StB2, StPad} state_e;

   localparam logic [COORD_W-1:0] One = COORD_W'(1);

   state_e                state_q, state_d;
   logic [WORD_SIZE-1:0]  b0_q, b0_d;
   logic [WORD_SIZE-1:0]  b1_q, b1_d;
   logic [COORD_W-1:0]    x_q, x_d;
   logic [COORD_W-1:0]    y_q, y_d;
   logic [COORD_W-1:0]    frame_q, frame_d;
   logic [DIM_W-1:0]      w_q, w_d;
   logic [DIM_W-1:0]      h_q, h_d;
   logic                  cfg_err_q, cfg_err_d;
   logic [1:0]            pad_cnt_q, pad_cnt_d;
   logic [PIXEL_SIZE-1:0] pixel_q, pixel_d;
   logic                  pixel_valid_q, pixel_valid_d;
   logic [COORD_W-1:0]    x_out_q, x_out_d;
   logic [COORD_W-1:0]    y_out_q, y_out_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;

   logic                  byte_ready;
   logic                  accept;
   logic                  frame_start;
   logic                  dims_bad;
   logic [COORD_W-1:0]    w_last;
   logic [COORD_W-1:0]    h_last;
   logic                  last_col;
   logic                  last_row;
   logic [1:0]            pad;

   assign byte_ready  = en_i && !cfg_err_q;
   assign accept      = byte_valid_i && byte_ready;
   assign frame_start = (state_q == StB0) && (x_q == '0) && (y_q == '0);
   assign dims_bad    = (img_width_i == '0) || (img_height_i == '0);
   assign w_last      = COORD_W'(w_q) - One;
   assign h_last      = COORD_W'(h_q) - One;
   assign last_col    = (x_q == w_last);
   assign last_row    = (y_q == h_last);
   // (4 - 3W mod 4) mod 4 reduces to W mod 4, since -3 == 1 (mod 4).
   assign pad         = w_q[1:0];

   // Next-state logic: byte FSM, coordinate/frame counters and registered pixel outputs.
   always_comb begin
      state_d       = state_q;
      b0_d          = b0_q;
      b1_d          = b1_q;
      x_d           = x_q;
      y_d           = y_q;
      frame_d       = frame_q;
      w_d           = w_q;
      h_d           = h_q;
      cfg_err_d     = cfg_err_q;
      pad_cnt_d     = pad_cnt_q;
      pixel_d       = pixel_q;
      pixel_valid_d = 1'b0;
      x_out_d       = x_out_q;
      y_out_d       = y_out_q;
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      if (accept) begin
         unique case (state_q)
            StB0: begin
               if (frame_start) begin
                  w_d = img_width_i;
                  h_d = img_height_i;
               end
               if (frame_start && dims_bad) begin
                  // Bad geometry: drop the byte and stall until reset.
                  cfg_err_d = 1'b1;
               end else begin
                  b0_d    = byte_in_i;
                  state_d = StB1;
               end
            end
            StB1: begin
               b1_d    = byte_in_i;
               state_d = StB2;
            end
            StB2: begin
               pixel_d       = {byte_in_i, b1_q, b0_q};
               pixel_valid_d = 1'b1;
               x_out_d       = x_q;
               y_out_d       = y_q;
               hsync_d       = (x_q == '0);
               vsync_d       = (x_q == '0) && (y_q == '0);
               if (last_col) begin
                  x_d = '0;
                  y_d = last_row ? '0 : y_q + One;
                  if (pad != 2'd0) begin
                     state_d   = StPad;
                     pad_cnt_d = pad;
                  end else begin
                     state_d = StB0;
                     if (last_row) frame_d = frame_q + One;
                  end
               end else begin
                  x_d     = x_q + One;
                  state_d = StB0;
               end
            end
            StPad: begin
               if (pad_cnt_q == 2'd1) begin
                  state_d = StB0;
                  // y already wrapped to 0 only when this padding ends the frame.
                  if (y_q == '0) frame_d = frame_q + One;
               end else begin
                  pad_cnt_d = pad_cnt_q - 2'd1;
               end
            end
            default: state_d = StB0;
         endcase
      end
   end

   // State and output registers with asynchronous active-high reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q       <= StB0;
         b0_q          <= '0;
         b1_q          <= '0;
         x_q           <= '0;
         y_q           <= '0;
         frame_q       <= '0;
         w_q           <= '0;
         h_q           <= '0;
         cfg_err_q     <= 1'b0;
         pad_cnt_q     <= '0;
         pixel_q       <= '0;
         pixel_valid_q <= 1'b0;
         x_out_q       <= '0;
         y_out_q       <= '0;
         hsync_q       <= 1'b0;
         vsync_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         b0_q          <= b0_d;
         b1_q          <= b1_d;
         x_q           <= x_d;
         y_q           <= y_d;
         frame_q       <= frame_d;
         w_q           <= w_d;
         h_q           <= h_d;
         cfg_err_q     <= cfg_err_d;
         pad_cnt_q     <= pad_cnt_d;
         pixel_q       <= pixel_d;
         pixel_valid_q <= pixel_valid_d;
         x_out_q       <= x_out_d;
         y_out_q       <= y_out_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
      end
   end

   assign byte_ready_o  = byte_ready;
   assign pixel_o       = pixel_q;
   assign pixel_valid_o = pixel_valid_q;
   assign x_o           = x_out_q;
   assign y_o           = y_out_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign frame_o       = frame_q;
   assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_bmp_pixel_streamer.sv
// Self-checking bench for bmp_pixel_streamer against a byte-position reference model.
module tb_bmp_pixel_streamer;

   logic        clk;
   logic        reset;
   logic        en;
   logic [15:0] img_width;
   logic [15:0] img_height;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_ready;
   logic [23:0] pixel;
   logic        pixel_valid;
   logic [31:0] x;
   logic [31:0] y;
   logic        hsync;
   logic        vsync;
   logic [31:0] frame;
   logic        cfg_err;

   bmp_pixel_streamer dut (
      .clk_i         (clk),
      .reset_i       (reset),
      .en_i          (en),
      .img_width_i   (img_width),
      .img_height_i  (img_height),
      .byte_in_i     (byte_in),
      .byte_valid_i  (byte_valid),
      .byte_ready_o  (byte_ready),
      .pixel_o       (pixel),
      .pixel_valid_o (pixel_valid),
      .x_o           (x),
      .y_o           (y),
      .hsync_o       (hsync),
      .vsync_o       (vsync),
      .frame_o       (frame),
      .cfg_err_o     (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: position of the next byte inside the current frame.
   int          m_p;
   int          m_w;
   int          m_h;
   logic [31:0] m_frame;
   logic        m_err;
   logic [7:0]  m_b [3];
   logic        exp_valid;
   logic [23:0] exp_pix;
   logic [31:0] exp_x;
   logic [31:0] exp_y;
   logic        exp_hs;
   logic        exp_vs;

   logic [15:0] cfg_w;
   logic [15:0] cfg_h;
   bit          scramble;
   logic [7:0]  seq_byte;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_p       = 0;
      m_w       = 0;
      m_h       = 0;
      m_frame   = '0;
      m_err     = 1'b0;
      exp_valid = 1'b0;
      exp_pix   = '0;
      exp_x     = '0;
      exp_y     = '0;
      exp_hs    = 1'b0;
      exp_vs    = 1'b0;
   endtask

   // Map an accepted byte to its row/column/lane from the padded row stride.
   task automatic model_byte(input logic [7:0] b);
      int stride, row, off, lane;
      if (m_p == 0) begin
         m_w = int'(img_width);
         m_h = int'(img_height);
         if (m_w == 0 || m_h == 0) m_err = 1'b1;
      end
      if (!m_err) begin
         stride = ((3 * m_w + 3) / 4) * 4;
         row    = m_p / stride;
         off    = m_p % stride;
         if (off < 3 * m_w) begin
            lane       = off % 3;
            m_b[lane]  = b;
            if (lane == 2) begin
               exp_valid = 1'b1;
               exp_pix   = {b, m_b[1], m_b[0]};
               exp_x     = 32'(off / 3);
               exp_y     = 32'(row);
               exp_hs    = (off / 3) == 0;
               exp_vs    = ((off / 3) == 0) && (row == 0);
            end
         end
         m_p++;
         if (m_p == stride * m_h) begin
            m_p     = 0;
            m_frame = m_frame + 32'd1;
         end
      end
   endtask

   // One clock of stimulus plus checks of every output against the model.
   task automatic step(input logic e, input logic v, input logic [7:0] b, output bit acc);
      logic exp_ready;
      @(negedge clk);
      en         = e;
      byte_valid = v;
      byte_in    = b;
      if (scramble && m_p != 0) begin
         img_width  = 16'($urandom_range(0, 7));
         img_height = 16'($urandom_range(0, 7));
      end else begin
         img_width  = cfg_w;
         img_height = cfg_h;
      end
      #1;
      exp_ready = e && !m_err;
      check("byte_ready", {63'd0, byte_ready}, {63'd0, exp_ready});
      acc       = v && exp_ready;
      exp_valid = 1'b0;
      if (acc) model_byte(b);
      @(posedge clk);
      #1;
      check("pixel_valid", {63'd0, pixel_valid}, {63'd0, exp_valid});
      check("pixel", {40'd0, pixel}, {40'd0, exp_pix});
      check("x", {32'd0, x}, {32'd0, exp_x});
      check("y", {32'd0, y}, {32'd0, exp_y});
      check("hsync", {63'd0, hsync}, {63'd0, exp_hs});
      check("vsync", {63'd0, vsync}, {63'd0, exp_vs});
      check("frame", {32'd0, frame}, {32'd0, m_frame});
      check("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
   endtask

   // mode 0: valid every cycle; 1: valid every other cycle; 2: random en/valid/data.
   task automatic feed(input int n, input int mode);
      int         sent;
      int         cyc;
      bit         acc;
      logic       e;
      logic       v;
      logic [7:0] b;
      sent = 0;
      cyc  = 0;
      while (sent < n && cyc < 8 * n + 32) begin
         if (mode == 0) begin
            e = 1'b1;
            v = 1'b1;
         end else if (mode == 1) begin
            e = 1'b1;
            v = (cyc % 2) == 0;
         end else begin
            e = $urandom_range(0, 3) != 0;
            v = $urandom_range(0, 2) != 0;
         end
         b = (mode == 2) ? 8'($urandom) : seq_byte;
         step(e, v, b, acc);
         if (acc) begin
            sent++;
            seq_byte = seq_byte + 8'd1;
         end
         cyc++;
      end
      check("feed_done", 64'(sent), 64'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      reset      = 1'b1;
      en         = 1'b0;
      byte_valid = 1'b0;
      #1;
      check("rst_pixel_valid", {63'd0, pixel_valid}, 64'd0);
      check("rst_pixel", {40'd0, pixel}, 64'd0);
      check("rst_x", {32'd0, x}, 64'd0);
      check("rst_y", {32'd0, y}, 64'd0);
      check("rst_hsync", {63'd0, hsync}, 64'd0);
      check("rst_vsync", {63'd0, vsync}, 64'd0);
      check("rst_frame", {32'd0, frame}, 64'd0);
      check("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
      check("rst_byte_ready", {63'd0, byte_ready}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      bit acc;
      reset      = 1'b0;
      en         = 1'b0;
      byte_valid = 1'b0;
      byte_in    = '0;
      cfg_w      = 16'd2;
      cfg_h      = 16'd2;
      img_width  = cfg_w;
      img_height = cfg_h;
      scramble   = 1'b0;
      seq_byte   = '0;
      model_reset();
      do_reset();

      // W=2 (pad 2), H=2, bytes 0x00..0x0F.
      seq_byte = '0;
      feed(16, 0);
      check("s1_frame", {32'd0, frame}, 64'd1);

      // W=4 (pad 0), H=1, two frames back to back.
      cfg_w = 16'd4;
      cfg_h = 16'd1;
      feed(24, 0);
      check("s2_frame", {32'd0, frame}, 64'd3);

      // W=1 (pad 1), H=3, valid every other cycle.
      cfg_w = 16'd1;
      cfg_h = 16'd3;
      feed(12, 1);

      // W=3, H=1: en low for 5 cycles after byte1 of pixel (1,0).
      cfg_w = 16'd3;
      cfg_h = 16'd1;
      feed(5, 0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, seq_byte, acc);
      feed(7, 0);

      // Random geometry, data, en and valid; dims scrambled mid-frame.
      scramble = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cfg_w = 16'($urandom_range(1, 6));
         cfg_h = 16'($urandom_range(1, 3));
         feed(((3 * int'(cfg_w) + 3) / 4) * 4 * int'(cfg_h), 2);
      end
      scramble = 1'b0;

      // Zero width at frame start: sticky error until reset.
      cfg_w = 16'd0;
      cfg_h = 16'd2;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'($urandom), acc);
      check("s5_cfg_err", {63'd0, cfg_err}, 64'd1);
      do_reset();

      // Reset in the middle of pixel (1,1); next three bytes form pixel (0,0).
      cfg_w    = 16'd3;
      cfg_h    = 16'd2;
      seq_byte = 8'h40;
      feed(17, 0);
      do_reset();
      feed(3, 0);
      check("s6_vsync", {63'd0, vsync}, 64'd1);
      check("s6_frame", {32'd0, frame}, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
